// File: rtl/decoder_3to8_pulse.sv
// decoder_3to8_pulse
//   Accepts a 3-bit index on a valid/ready handshake. It drives the matching
//   one-hot code on y for PULSE_LEN cycles, then returns to idle. Dropping
//   enable during a pulse aborts it.
//
// Ports
//   clk          single clock, rising edge
//   reset        asynchronous, active-high
//   enable       block enable; low blocks requests and aborts an active pulse
//   in_valid     request present on a
//   a            binary index 0..7
//   in_ready     request can be taken this cycle (from state and enable only)
//   y            registered one-hot output, held for the whole pulse
//   busy         high while ACTIVE
//   done         one-cycle strobe after a pulse completes normally
//   pulse_count  completed pulses, wraps modulo 256
//
// state  | meaning
// IDLE   | y is zero; waits for in_valid && in_ready
// ACTIVE | y holds the latched code; cnt counts down to the final cycle
module decoder_3to8_pulse #(
  parameter int unsigned PULSE_LEN = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       in_valid,
  input  logic [2:0] a,
  output logic       in_ready,
  output logic [7:0] y,
  output logic       busy,
  output logic       done,
  output logic [7:0] pulse_count
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // cnt starts at PULSE_LEN-1 and the pulse ends on the edge where it is zero.
  // This keeps y high for exactly PULSE_LEN cycles.
  localparam logic [7:0] CNT_LOAD = 8'(PULSE_LEN - 1);

  state_t     state;
  logic [7:0] cnt;

  assign in_ready = (state == IDLE) && enable;
  assign busy     = (state == ACTIVE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      y           <= 8'h00;
      cnt         <= 8'h00;
      done        <= 1'b0;
      pulse_count <= 8'h00;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            y     <= 8'h01 << a;
            cnt   <= CNT_LOAD;
            state <= ACTIVE;
          end
        end
        ACTIVE: begin
          // An abort is checked first, so it wins over a completion on the same edge.
          if (!enable) begin
            y     <= 8'h00;
            cnt   <= 8'h00;
            state <= IDLE;
          end else if (cnt == 8'h00) begin
            y           <= 8'h00;
            state       <= IDLE;
            done        <= 1'b1;
            pulse_count <= pulse_count + 8'h01;
          end else begin
            cnt <= cnt - 8'h01;
          end
        end
        default: begin
          y     <= 8'h00;
          cnt   <= 8'h00;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_3to8_pulse.sv
// Directed bench for decoder_3to8_pulse.
// One instance uses PULSE_LEN=4 and a second uses PULSE_LEN=1; both share the stimulus.
module tb_decoder_3to8_pulse;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       in_valid;
  logic [2:0] a;

  logic       in_ready, busy, done;
  logic [7:0] y, pulse_count;
  logic       in_ready1, busy1, done1;
  logic [7:0] y1, pc1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  decoder_3to8_pulse #(.PULSE_LEN(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid), .a(a),
    .in_ready(in_ready), .y(y), .busy(busy), .done(done), .pulse_count(pulse_count)
  );

  decoder_3to8_pulse #(.PULSE_LEN(1)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid), .a(a),
    .in_ready(in_ready1), .y(y1), .busy(busy1), .done(done1), .pulse_count(pc1)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    enable   = 1'b0;
    a        = 3'd0;
    step();
    step();
    reset  = 1'b0;
    enable = 1'b1;
    #1;
  endtask

  // Presents av for one accept edge, then scrambles a so a late sample would show.
  task automatic issue(input logic [2:0] av);
    a        = av;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    a        = ~av;
  endtask

  logic [7:0] one8 = 8'h01;
  logic [7:0] code;
  int         n;
  int         ndone;
  logic       multi_hot;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    reset = 1'b1; enable = 1'b1; in_valid = 1'b1; a = 3'd3;
    step();
    step();
    check("rst_y", y, 8'h00);
    check("rst_busy", 8'(busy), 8'h00);
    check("rst_done", 8'(done), 8'h00);
    check("rst_pc", pulse_count, 8'h00);
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("rdy_after_rst", 8'(in_ready), 8'h01);

    // single request, a=5
    do_reset();
    issue(3'd5);
    for (int i = 0; i < 4; i++) begin
      check("single_y", y, 8'h20);
      check("single_busy", 8'(busy), 8'h01);
      check("single_done_low", 8'(done), 8'h00);
      step();
    end
    check("single_y_end", y, 8'h00);
    check("single_done", 8'(done), 8'h01);
    check("single_pc", pulse_count, 8'h01);
    step();
    check("single_done_1cyc", 8'(done), 8'h00);

    // sweep a=0..7, back to back
    do_reset();
    for (int k = 0; k < 8; k++) begin
      n = 0;
      while (!in_ready && n < 20) begin
        step();
        n++;
      end
      if (n >= 20) check("sweep_timeout", 8'h00, 8'h01);
      issue(3'(k));
      code = one8 << k;
      for (int i = 0; i < 4; i++) begin
        check("sweep_y", y, code);
        step();
      end
      check("sweep_done", 8'(done), 8'h01);
      check("sweep_rdy_done", 8'(in_ready), 8'h01);
    end
    check("sweep_pc", pulse_count, 8'h08);

    // abort in the second ACTIVE cycle
    do_reset();
    issue(3'd3);
    check("abort_y1", y, 8'h08);
    step();
    check("abort_y2", y, 8'h08);
    enable = 1'b0;
    #1;
    check("abort_rdy", 8'(in_ready), 8'h00);
    step();
    check("abort_y", y, 8'h00);
    check("abort_busy", 8'(busy), 8'h00);
    check("abort_done", 8'(done), 8'h00);
    for (int i = 0; i < 3; i++) begin
      step();
      check("abort_done_hold", 8'(done), 8'h00);
      check("abort_rdy_hold", 8'(in_ready), 8'h00);
    end
    check("abort_pc", pulse_count, 8'h00);
    enable = 1'b1;
    #1;
    check("abort_rdy_back", 8'(in_ready), 8'h01);

    // change a mid-pulse with in_valid held high
    do_reset();
    a = 3'd2;
    in_valid = 1'b1;
    step();
    a = 3'd7;
    for (int i = 0; i < 4; i++) begin
      check("midchg_y", y, 8'h04);
      check("midchg_rdy", 8'(in_ready), 8'h00);
      step();
    end
    check("midchg_done", 8'(done), 8'h01);
    check("midchg_gap_y", y, 8'h00);
    step();
    in_valid = 1'b0;
    check("midchg_second_y", y, 8'h80);
    for (int i = 0; i < 3; i++) step();
    check("midchg_second_hold", y, 8'h80);
    step();
    check("midchg_pc", pulse_count, 8'h02);

    // reset raised between edges during a pulse
    do_reset();
    issue(3'd4);
    step();
    check("rstmid_pre_y", y, 8'h10);
    #3;
    reset = 1'b1;
    #1;
    check("rstmid_y", y, 8'h00);
    check("rstmid_busy", 8'(busy), 8'h00);
    check("rstmid_done", 8'(done), 8'h00);
    check("rstmid_pc", pulse_count, 8'h00);
    step();
    reset = 1'b0;
    step();
    check("rstmid_done_after", 8'(done), 8'h00);
    check("rstmid_y_after", y, 8'h00);

    // PULSE_LEN=1: single-cycle pulse, then abort on the zero-count cycle
    do_reset();
    issue(3'd6);
    check("p1_y", y1, 8'h40);
    check("p1_busy", 8'(busy1), 8'h01);
    step();
    check("p1_y_end", y1, 8'h00);
    check("p1_done", 8'(done1), 8'h01);
    check("p1_pc", pc1, 8'h01);
    issue(3'd1);
    check("p1_y2", y1, 8'h02);
    enable = 1'b0;
    step();
    check("prio_y", y1, 8'h00);
    check("prio_done", 8'(done1), 8'h00);
    check("prio_pc", pc1, 8'h01);
    enable = 1'b1;

    // 256 completed pulses wrap pulse_count to 0
    do_reset();
    in_valid  = 1'b1;
    ndone     = 0;
    multi_hot = 1'b0;
    for (int c = 0; c < 1000 && ndone < 256; c++) begin
      a = 3'(c);
      step();
      if ((y1 & (y1 - 8'h01)) != 8'h00) multi_hot = 1'b1;
      if ((y & (y - 8'h01)) != 8'h00) multi_hot = 1'b1;
      if (done1) begin
        ndone++;
        if (ndone == 255) check("wrap_pc_ff", pc1, 8'hff);
      end
    end
    in_valid = 1'b0;
    check("wrap_reached", 8'(ndone == 256), 8'h01);
    check("wrap_pc", pc1, 8'h00);
    check("onehot", 8'(multi_hot), 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
